// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a shared single-port memory
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              if_stall,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        owner
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [2:0] {IDLE, G_I, G_D, R_I, R_D} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             arb, f_elig, d_elig, grant_i, grant_d;

  // The port that just completed sits out one arbitration round.
  always_comb begin
    arb     = (state == IDLE) || (state == R_I) || (state == R_D);
    f_elig  = arb && if_req && (state != R_I);
    d_elig  = arb && d_req && (state != R_D);
    grant_d = d_elig && (!f_elig || (starve_cnt != STARVE_LIM));
    grant_i = f_elig && !grant_d;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, R_I, R_D: begin
        if (grant_d)      state_nxt = G_D;
        else if (grant_i) state_nxt = G_I;
        else              state_nxt = IDLE;
      end
      G_I:     if (mem_ack) state_nxt = R_I;
      G_D:     if (mem_ack) state_nxt = R_D;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (!if_req || grant_i)
      starve_nxt = '0;
    else if (grant_d && (starve_cnt != STARVE_LIM))
      starve_nxt = starve_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (grant_d) begin
        mem_addr  <= d_addr;
        mem_we    <= d_we;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        mem_addr  <= if_addr;
        mem_we    <= 1'b0;
        mem_wdata <= '0;
      end
      if ((state == G_I) && mem_ack)
        if_rdata <= mem_rdata;
      if ((state == G_D) && mem_ack && !mem_we)
        d_rdata <= mem_rdata;
    end
  end

  assign mem_en   = (state == G_I) || (state == G_D);
  assign if_ready = (state == R_I);
  assign d_ready  = (state == R_D);
  assign if_stall = if_req && !if_ready;
  assign d_stall  = d_req && !d_ready;
  assign owner    = (state == G_I) ? 2'b01 : (state == G_D) ? 2'b10 : 2'b00;

endmodule
